easy_axi_rd_mst: RTL and testbench
==================================

# easy_axi_rd_mst

AXI read master traffic generator that drives the AR channel of the easy AXI read slave and consumes its R channel. When enabled, it issues a fixed sequence of read bursts with up to `OST_DEPTH` outstanding. It tracks the expected burst length of each outstanding request in order and checks every returned beat. It is the block directly upstream of the slave and stands in for a real CPU or DMA master in the easy_axi bring-up bench.

## Interface
Parameters:
- `OST_DEPTH`, 4, maximum outstanding read requests; must be a power of 2, ≥ 2.
- `REQ_NUM`, 8, number of AR requests issued per run; range 1..255.
- `BASE_ADDR`, 0, value driven on `araddr` for every request.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request (level).
- `axi_mst_arvalid` out 1, `axi_mst_arready` in 1: AR handshake.
- `axi_mst_arid` out `AXI_ID_W`: read request ID.
- `axi_mst_araddr` out `AXI_ADDR_W`: read address.
- `axi_mst_arlen` out `AXI_LEN_W`: burst length minus one.
- `axi_mst_arsize` out `AXI_SIZE_W`: beat size.
- `axi_mst_arburst` out `AXI_BURST_W`: burst type.
- `axi_mst_rvalid` in 1, `axi_mst_rready` out 1: R handshake.
- `axi_mst_rdata` in `AXI_DATA_W`: read data.
- `axi_mst_rresp` in `AXI_RESP_W`: read response.
- `axi_mst_rlast` in 1: last beat of burst.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: run complete.
- `err_cnt` out 8: saturating error count for the current run.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN: `enable`=1. On this transition, clear `err_cnt` and the request index.
  - RUN→DRAIN: request index = `REQ_NUM` after an AR handshake, or `enable`=0 while `arvalid`=0.
  - DRAIN→DONE: outstanding count = 0 and no R handshake in the current cycle.
  - DONE→IDLE: `enable`=0.
- Request payload for request index k:
  - `arid` = k[`AXI_ID_W`-1:0].
  - `araddr` = `BASE_ADDR`.
  - `arlen` = k mod 4.
  - `arsize` = `AXI_SIZE_FULL`.
  - `arburst` = `AXI_BURST_INCR`.
- AR rules:
  - Assert `arvalid` only in RUN, and only when outstanding count < `OST_DEPTH`.
  - Once asserted, `arvalid` and the payload stay stable until `arready`. This holds even if `enable` drops; after that handshake the FSM moves to DRAIN.
- On each AR handshake, push `arlen` into the outstanding FIFO and increment the request index.
- R rules:
  - `rready` = 1 whenever the FIFO is non-empty (RUN or DRAIN).
  - A beat counter starts at 0 for the FIFO head.
- Per-beat checks on each R handshake; each failed check adds 1 to `err_cnt`, saturating at 255:
  - `rdata` ≠ zero-extended beat counter.
  - `rresp` ≠ `AXI_RESP_OKAY`.
  - `rlast` ≠ (beat counter == head len).
- Burst retirement:
  - The burst retires, popping the FIFO and zeroing the beat counter, when beat counter == head len **or** `rlast`=1.
  - An early `rlast` therefore resynchronises the checker to the next burst.
  - A missing `rlast` does not stall the checker.
- A push and a pop in the same cycle leave the outstanding count unchanged.

## Timing
- Reset values:
  - `arvalid`=0, `rready`=0, `arid`=0, `araddr`=`BASE_ADDR`, `arlen`=0.
  - `arsize`=`AXI_SIZE_FULL`, `arburst`=`AXI_BURST_INCR`.
  - `busy`=0, `done`=0, `err_cnt`=0.
  - FSM in IDLE, FIFO empty.
- All outputs are registered except `rready`, which is decoded from registered FIFO state.
- Latency:
  - First `arvalid` is asserted 2 cycles after `enable` rises (IDLE→RUN, then arvalid set).
  - Back-to-back AR is allowed: after a handshake, the next request is driven in the following cycle if credit remains.
- `done` rises 1 cycle after the final retiring R handshake. It stays high until `enable`=0, then drops the next cycle.
- Reset mid-operation clears everything immediately. Any in-flight slave transaction is abandoned; the slave is reset by the same `rst_n`.

## Structure
- Add the following to the shared `easy_axi_define.v`:
  - `AXI_BURST_INCR` (2'b01).
  - `AXI_RESP_OKAY` (2'b00).
  - `AXI_SIZE_FULL` = log2(`AXI_DATA_W`/8).
  - The existing width macros are reused.
- Sub-module `easy_axi_sync_fifo`:
  - Parameters: width, depth.
  - Ports: push, pop, `full`, `empty`, `count`, head data.
  - It holds the outstanding `arlen` values.

## Test plan
- Reset: with `rst_n` held low and the bus toggling, all outputs hold their reset values. After release with `enable`=0, state stays IDLE and `arvalid`=0.
- Against the easy AXI slave, `REQ_NUM`=8, `BASE_ADDR`=0:
  - 8 ARs are issued with ids 0..7 and lens 0,1,2,3,0,1,2,3.
  - 20 R beats return with data 0..len.
  - Final state: `done`=1, `err_cnt`=0.
- Bus-model slave with `arready`=1 and `rvalid` held 0: exactly 4 ARs are accepted, then `arvalid`=0. Releasing R for one burst allows exactly one more AR.
- Error checking, from the initial `err_cnt`=0:
  - Bus model returns `rdata`=5 on beat 1 of a len-3 burst: `err_cnt`=1.
  - Next burst returns `rresp`=2'b10 on one beat: `err_cnt`=2.
  - A len-2 burst ends with `rlast` on beat 0: `err_cnt`=3, and the following burst checks clean.
- `enable` dropped while `arvalid`=1 and `arready`=0: `arvalid` holds with a stable payload until `arready`, no further AR is issued, and `done` is asserted after outstanding bursts drain.
- Reset asserted mid-burst with 3 outstanding: the next cycle shows reset values and an empty FIFO. A new run starts from id 0 with `err_cnt`=0.

Source files
------------

// File: rtl/easy_axi_rd_mst_pkg.sv
// Shared AXI widths, encodings and the read-master FSM state type.
// Every file that needs these values imports this package.
package easy_axi_rd_mst_pkg;

    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_ADDR_W  = 32;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_DATA_W  = 32;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_FULL  = AXI_SIZE_W'($clog2(AXI_DATA_W / 8));

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } mst_state_e;

    // Adds 0..3 to an 8-bit counter, saturating at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

endpackage

// File: rtl/easy_axi_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; the head entry is shown on o_rdata.
// Depth must be a power of two so the pointers wrap naturally.
module easy_axi_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [Width-1:0] i_wdata,
    output logic            o_full,
    output logic            o_empty,
    output logic [CntW-1:0] o_count,
    output logic [Width-1:0] o_rdata
);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/easy_axi_rd_mst.sv
// AXI read traffic generator: issues REQ_NUM bursts with bounded outstanding credit
// and checks every returned beat against the expected counting pattern.
module easy_axi_rd_mst
    import easy_axi_rd_mst_pkg::*;
#(
    parameter int unsigned          OST_DEPTH = 4,
    parameter int unsigned          REQ_NUM   = 8,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   axi_mst_arvalid,
    input  logic                   axi_mst_arready,
    output logic [AXI_ID_W-1:0]    axi_mst_arid,
    output logic [AXI_ADDR_W-1:0]  axi_mst_araddr,
    output logic [AXI_LEN_W-1:0]   axi_mst_arlen,
    output logic [AXI_SIZE_W-1:0]  axi_mst_arsize,
    output logic [AXI_BURST_W-1:0] axi_mst_arburst,
    input  logic                   axi_mst_rvalid,
    output logic                   axi_mst_rready,
    input  logic [AXI_DATA_W-1:0]  axi_mst_rdata,
    input  logic [AXI_RESP_W-1:0]  axi_mst_rresp,
    input  logic                   axi_mst_rlast,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             err_cnt
);

    localparam int unsigned CNT_W = $clog2(OST_DEPTH) + 1;

    mst_state_e           r_state;
    mst_state_e           w_state_d;
    logic [7:0]           r_req_idx;
    logic [7:0]           w_req_idx_d;
    logic                 r_arvalid;
    logic                 w_arvalid_d;
    logic [AXI_ID_W-1:0]  r_arid;
    logic [AXI_ID_W-1:0]  w_arid_d;
    logic [AXI_LEN_W-1:0] r_arlen;
    logic [AXI_LEN_W-1:0] w_arlen_d;
    logic [AXI_LEN_W-1:0] r_beat;
    logic [AXI_LEN_W-1:0] w_beat_d;
    logic [7:0]           r_err_cnt;
    logic [7:0]           w_err_d;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_clr_err;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic                 w_retire;
    logic                 w_credit;
    logic [1:0]           w_n_err;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [AXI_LEN_W-1:0] w_head_len;

    assign w_ar_hs  = r_arvalid && axi_mst_arready;
    assign w_r_hs   = axi_mst_rvalid && !w_fifo_empty;
    assign w_retire = w_r_hs && ((r_beat == w_head_len) || axi_mst_rlast);

    easy_axi_sync_fifo #(
        .Width(AXI_LEN_W),
        .Depth(OST_DEPTH)
    ) u_ost_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_ar_hs && !w_fifo_full),
        .i_pop  (w_retire),
        .i_wdata(r_arlen),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty),
        .o_count(w_fifo_count),
        .o_rdata(w_head_len)
    );

    // Occupancy after this cycle; a new AR is only raised if it will still fit.
    always_comb begin
        w_cnt_next = w_fifo_count;
        if (w_ar_hs && !w_retire) begin
            w_cnt_next = w_fifo_count + CNT_W'(1);
        end else if (!w_ar_hs && w_retire) begin
            w_cnt_next = w_fifo_count - CNT_W'(1);
        end
    end

    assign w_credit = (w_cnt_next < CNT_W'(OST_DEPTH));

    always_comb begin
        w_state_d   = r_state;
        w_req_idx_d = r_req_idx;
        w_arvalid_d = r_arvalid;
        w_arid_d    = r_arid;
        w_arlen_d   = r_arlen;
        w_clr_err   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (enable) begin
                    w_state_d   = StRun;
                    w_req_idx_d = '0;
                    w_clr_err   = 1'b1;
                end
            end
            StRun: begin
                if (w_ar_hs) begin
                    w_req_idx_d = r_req_idx + 8'd1;
                    w_arvalid_d = 1'b0;
                    if ((w_req_idx_d == 8'(REQ_NUM)) || !enable) begin
                        w_state_d = StDrain;
                    end else if (w_credit) begin
                        w_arvalid_d = 1'b1;
                        w_arid_d    = w_req_idx_d[AXI_ID_W-1:0];
                        w_arlen_d   = AXI_LEN_W'(w_req_idx_d[1:0]);
                    end
                end else if (!r_arvalid) begin
                    if (!enable) begin
                        w_state_d = StDrain;
                    end else if (w_credit) begin
                        w_arvalid_d = 1'b1;
                        w_arid_d    = r_req_idx[AXI_ID_W-1:0];
                        w_arlen_d   = AXI_LEN_W'(r_req_idx[1:0]);
                    end
                end
            end
            StDrain: begin
                if (w_fifo_empty && !w_r_hs) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (!enable) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_n_err  = '0;
        w_beat_d = r_beat;
        if (w_r_hs) begin
            w_n_err = {1'b0, (axi_mst_rdata != AXI_DATA_W'(r_beat))}
                    + {1'b0, (axi_mst_rresp != AXI_RESP_OKAY)}
                    + {1'b0, (axi_mst_rlast != (r_beat == w_head_len))};
            w_beat_d = w_retire ? '0 : r_beat + AXI_LEN_W'(1);
        end
        w_err_d = w_clr_err ? 8'd0 : sat_add8(r_err_cnt, w_n_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_req_idx <= '0;
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_arlen   <= '0;
            r_beat    <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_req_idx <= w_req_idx_d;
            r_arvalid <= w_arvalid_d;
            r_arid    <= w_arid_d;
            r_arlen   <= w_arlen_d;
            r_beat    <= w_beat_d;
            r_err_cnt <= w_err_d;
            r_busy    <= (w_state_d == StRun) || (w_state_d == StDrain);
            r_done    <= (w_state_d == StDone);
        end
    end

    assign axi_mst_arvalid = r_arvalid;
    assign axi_mst_arid    = r_arid;
    assign axi_mst_araddr  = BASE_ADDR;
    assign axi_mst_arlen   = r_arlen;
    assign axi_mst_arsize  = AXI_SIZE_FULL;
    assign axi_mst_arburst = AXI_BURST_INCR;
    assign axi_mst_rready  = !w_fifo_empty;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_easy_axi_rd_mst.sv
// Directed bench for easy_axi_rd_mst with a small in-order AXI read slave model
// that can throttle AR/R and corrupt selected beats.
module tb_easy_axi_rd_mst;
    import easy_axi_rd_mst_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   enable = 1'b0;
    logic                   axi_mst_arvalid;
    logic                   axi_mst_arready = 1'b0;
    logic [AXI_ID_W-1:0]    axi_mst_arid;
    logic [AXI_ADDR_W-1:0]  axi_mst_araddr;
    logic [AXI_LEN_W-1:0]   axi_mst_arlen;
    logic [AXI_SIZE_W-1:0]  axi_mst_arsize;
    logic [AXI_BURST_W-1:0] axi_mst_arburst;
    logic                   axi_mst_rvalid = 1'b0;
    logic                   axi_mst_rready;
    logic [AXI_DATA_W-1:0]  axi_mst_rdata = '0;
    logic [AXI_RESP_W-1:0]  axi_mst_rresp = '0;
    logic                   axi_mst_rlast = 1'b0;
    logic                   busy;
    logic                   done;
    logic [7:0]             err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model configuration and bookkeeping
    bit s_auto       = 1'b0;
    bit s_arready_en = 1'b1;
    int s_ar_limit   = 1000;
    int s_rlimit     = 1000;
    int s_ar_cnt     = 0;
    int s_burst_started = 0;
    int s_bursts_done   = 0;
    int s_beats_total   = 0;
    bit s_cur_act = 1'b0;
    int s_cur_len = 0;
    int s_cur_idx = 0;
    int s_beat    = 0;
    bit s_p_hs    = 1'b0;
    bit s_p_last  = 1'b0;
    int aq[$];
    int ar_id_log[16];
    int ar_len_log[16];
    int err_snap[16];
    int fault_kind[8];
    int fault_beat[8];
    int exp_len[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    easy_axi_rd_mst #(
        .OST_DEPTH(4),
        .REQ_NUM  (8),
        .BASE_ADDR(32'h0)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .axi_mst_arvalid(axi_mst_arvalid),
        .axi_mst_arready(axi_mst_arready),
        .axi_mst_arid   (axi_mst_arid),
        .axi_mst_araddr (axi_mst_araddr),
        .axi_mst_arlen  (axi_mst_arlen),
        .axi_mst_arsize (axi_mst_arsize),
        .axi_mst_arburst(axi_mst_arburst),
        .axi_mst_rvalid (axi_mst_rvalid),
        .axi_mst_rready (axi_mst_rready),
        .axi_mst_rdata  (axi_mst_rdata),
        .axi_mst_rresp  (axi_mst_rresp),
        .axi_mst_rlast  (axi_mst_rlast),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    // Decisions made on the falling edge take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            s_ar_cnt = 0; s_burst_started = 0; s_bursts_done = 0; s_beats_total = 0;
            s_cur_act = 1'b0; s_beat = 0; s_p_hs = 1'b0; s_p_last = 1'b0;
            aq.delete();
            for (int i = 0; i < 16; i++) begin
                ar_id_log[i] = -1; ar_len_log[i] = -1; err_snap[i] = -1;
            end
            if (s_auto) begin
                axi_mst_arready = 1'b0; axi_mst_rvalid = 1'b0; axi_mst_rlast = 1'b0;
            end
        end else if (s_auto) begin
            if (s_p_hs) begin
                s_beats_total++;
                if (s_p_last) begin
                    s_cur_act = 1'b0;
                    if (s_bursts_done < 16) err_snap[s_bursts_done] = int'(err_cnt);
                    s_bursts_done++;
                end else begin
                    s_beat++;
                end
            end
            if (!s_cur_act && aq.size() > 0 && s_burst_started < s_rlimit) begin
                s_cur_len = aq.pop_front();
                s_cur_idx = s_burst_started;
                s_cur_act = 1'b1;
                s_beat    = 0;
                s_burst_started++;
            end
            if (s_cur_act) begin
                axi_mst_rvalid = 1'b1;
                axi_mst_rdata  = AXI_DATA_W'(s_beat);
                axi_mst_rresp  = 2'b00;
                axi_mst_rlast  = (s_beat == s_cur_len);
                if (s_cur_idx < 8 && s_beat == fault_beat[s_cur_idx]) begin
                    if (fault_kind[s_cur_idx] == 1) axi_mst_rdata = 32'd5;
                    if (fault_kind[s_cur_idx] == 2) axi_mst_rresp = 2'b10;
                    if (fault_kind[s_cur_idx] == 3) axi_mst_rlast = 1'b1;
                end
            end else begin
                axi_mst_rvalid = 1'b0;
                axi_mst_rlast  = 1'b0;
                axi_mst_rdata  = '0;
            end
            s_p_hs   = axi_mst_rvalid && axi_mst_rready;
            s_p_last = axi_mst_rlast;
            axi_mst_arready = s_arready_en && (s_ar_cnt < s_ar_limit);
            if (axi_mst_arvalid && axi_mst_arready) begin
                if (s_ar_cnt < 16) begin
                    ar_id_log[s_ar_cnt]  = int'(axi_mst_arid);
                    ar_len_log[s_ar_cnt] = int'(axi_mst_arlen);
                end
                aq.push_back(int'(axi_mst_arlen));
                s_ar_cnt++;
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        s_arready_en = 1'b1;
        s_ar_limit = 1000;
        s_rlimit = 1000;
        for (int i = 0; i < 8; i++) begin
            fault_kind[i] = 0;
            fault_beat[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        s_auto = 1'b0;
        rst_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            axi_mst_arready = 1'($urandom_range(0, 1));
            axi_mst_rvalid  = 1'($urandom_range(0, 1));
            axi_mst_rlast   = 1'($urandom_range(0, 1));
            axi_mst_rresp   = 2'($urandom_range(0, 3));
            axi_mst_rdata   = $urandom;
            enable          = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if ({axi_mst_arvalid, axi_mst_rready, busy, done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ctrl: arvalid/rready/busy/done=%b required 0000",
                         {axi_mst_arvalid, axi_mst_rready, busy, done});
            end
            n_checks++;
            if ({axi_mst_arid, axi_mst_araddr, axi_mst_arlen, err_cnt} !== 52'd0) begin
                n_fail++;
                $display("FAIL reset_payload: arid=%0d araddr=%0h arlen=%0d err=%0d required 0",
                         axi_mst_arid, axi_mst_araddr, axi_mst_arlen, err_cnt);
            end
            n_checks++;
            if ({axi_mst_arsize, axi_mst_arburst} !== {3'd2, 2'b01}) begin
                n_fail++;
                $display("FAIL reset_size_burst: arsize=%0d arburst=%b required 2/01",
                         axi_mst_arsize, axi_mst_arburst);
            end
        end
        @(negedge clk);
        enable = 1'b0;
        axi_mst_arready = 1'b0;
        axi_mst_rvalid = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({axi_mst_arvalid, busy, axi_mst_rready} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_after_reset: arvalid/busy/rready=%b required 000",
                         {axi_mst_arvalid, busy, axi_mst_rready});
            end
        end
        s_auto = 1'b1;
    endtask

    task automatic test_normal();
        int cyc;
        start_run();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({axi_mst_arvalid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL first_cycle: arvalid/busy=%b required 01", {axi_mst_arvalid, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({axi_mst_arvalid, axi_mst_arid, axi_mst_arlen} !== {1'b1, 4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL first_ar: arvalid=%b arid=%0d arlen=%0d required 1/0/0",
                     axi_mst_arvalid, axi_mst_arid, axi_mst_arlen);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_done_timeout: done=%b required 1", done);
        end
        n_checks++;
        if (s_ar_cnt != 8) begin
            n_fail++;
            $display("FAIL normal_ar_count: got %0d required 8", s_ar_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (ar_id_log[i] != i || ar_len_log[i] != exp_len[i]) begin
                n_fail++;
                $display("FAIL normal_ar_payload[%0d]: id=%0d len=%0d required id=%0d len=%0d",
                         i, ar_id_log[i], ar_len_log[i], i, exp_len[i]);
            end
        end
        n_checks++;
        if (s_beats_total != 20) begin
            n_fail++;
            $display("FAIL normal_beats: got %0d required 20", s_beats_total);
        end
        n_checks++;
        if ({busy, err_cnt} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL normal_final: busy=%b err_cnt=%0d required 0/0", busy, err_cnt);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: done=%b required 1", done);
        end
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_drop: done=%b required 0", done);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        start_run();
        s_rlimit = 0;
        @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (s_ar_cnt != 4 || axi_mst_arvalid !== 1'b0 || axi_mst_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_stall: ars=%0d arvalid=%b rready=%b required 4/0/1",
                     s_ar_cnt, axi_mst_arvalid, axi_mst_rready);
        end
        s_rlimit = 1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (s_ar_cnt != 5 || s_bursts_done != 1 || axi_mst_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_return: ars=%0d bursts=%0d arvalid=%b required 5/1/0",
                     s_ar_cnt, s_bursts_done, axi_mst_arvalid);
        end
        s_rlimit = 1000;
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1 || s_ar_cnt != 8 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL bp_finish: done=%b ars=%0d err=%0d required 1/8/0",
                     done, s_ar_cnt, err_cnt);
        end
    endtask

    task automatic test_errors();
        int cyc;
        start_run();
        fault_kind[3] = 1; fault_beat[3] = 1;
        fault_kind[4] = 2; fault_beat[4] = 0;
        fault_kind[6] = 3; fault_beat[6] = 0;
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL err_done_timeout: done=%b required 1", done);
        end
        n_checks++;
        if (err_snap[0] != 0 || err_snap[2] != 0) begin
            n_fail++;
            $display("FAIL err_clean_start: snaps=%0d/%0d required 0/0", err_snap[0], err_snap[2]);
        end
        n_checks++;
        if (err_snap[3] != 1) begin
            n_fail++;
            $display("FAIL err_data: err_cnt=%0d required 1", err_snap[3]);
        end
        n_checks++;
        if (err_snap[4] != 2 || err_snap[5] != 2) begin
            n_fail++;
            $display("FAIL err_resp: err_cnt=%0d/%0d required 2/2", err_snap[4], err_snap[5]);
        end
        n_checks++;
        if (err_snap[6] != 3) begin
            n_fail++;
            $display("FAIL err_early_last: err_cnt=%0d required 3", err_snap[6]);
        end
        n_checks++;
        if (err_snap[7] != 3 || err_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL err_resync: snap=%0d final=%0d required 3/3", err_snap[7], err_cnt);
        end
        n_checks++;
        if (s_bursts_done != 8 || s_beats_total != 18) begin
            n_fail++;
            $display("FAIL err_beats: bursts=%0d beats=%0d required 8/18",
                     s_bursts_done, s_beats_total);
        end
    endtask

    task automatic test_enable_drop();
        int cyc;
        start_run();
        s_arready_en = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        while (axi_mst_arvalid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (axi_mst_arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_arvalid_timeout: arvalid=%b required 1", axi_mst_arvalid);
        end
        enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({axi_mst_arvalid, busy, axi_mst_arid, axi_mst_arlen} !== {2'b11, 4'd0, 8'd0}) begin
                n_fail++;
                $display("FAIL drop_hold: arvalid=%b busy=%b arid=%0d arlen=%0d required 1/1/0/0",
                         axi_mst_arvalid, busy, axi_mst_arid, axi_mst_arlen);
            end
        end
        s_arready_en = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1 || s_ar_cnt != 1 || s_beats_total != 1) begin
            n_fail++;
            $display("FAIL drop_drain: done=%b ars=%0d beats=%0d required 1/1/1",
                     done, s_ar_cnt, s_beats_total);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, axi_mst_arvalid} !== 3'b000 || s_ar_cnt != 1) begin
            n_fail++;
            $display("FAIL drop_idle: done/busy/arvalid=%b ars=%0d required 000/1",
                     {done, busy, axi_mst_arvalid}, s_ar_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_run();
        fault_kind[0] = 1; fault_beat[0] = 0;
        s_ar_limit = 4;
        s_rlimit = 1;
        @(negedge clk);
        enable = 1'b1;
        repeat (25) @(negedge clk);
        n_checks++;
        if (s_ar_cnt != 4 || s_bursts_done != 1 || err_cnt !== 8'd1 || axi_mst_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: ars=%0d bursts=%0d err=%0d rready=%b required 4/1/1/1",
                     s_ar_cnt, s_bursts_done, err_cnt, axi_mst_rready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({axi_mst_arvalid, axi_mst_rready, busy, done} !== 4'b0000 ||
            {axi_mst_arid, axi_mst_arlen, err_cnt} !== 20'd0) begin
            n_fail++;
            $display("FAIL mid_reset: arvalid=%b rready=%b busy=%b done=%b arid=%0d err=%0d required 0",
                     axi_mst_arvalid, axi_mst_rready, busy, done, axi_mst_arid, err_cnt);
        end
        @(negedge clk);
        fault_kind[0] = 0;
        s_ar_limit = 1000;
        s_rlimit = 1000;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (done !== 1'b1 || ar_id_log[0] != 0 || s_ar_cnt != 8) begin
            n_fail++;
            $display("FAIL mid_rerun: done=%b first_id=%0d ars=%0d required 1/0/8",
                     done, ar_id_log[0], s_ar_cnt);
        end
        n_checks++;
        if (err_cnt !== 8'd0 || s_beats_total != 20) begin
            n_fail++;
            $display("FAIL mid_rerun_clean: err=%0d beats=%0d required 0/20",
                     err_cnt, s_beats_total);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_errors();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
